// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI master files.
//   SPI_WIDTH   - bits per transfer
//   spi_state_t - master FSM states: IDLE, LOW (sclk low phase), HIGH (sclk high phase)
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: sclk half-period timer.
// Emits a one-cycle tick every HALF_PERIOD clk cycles while en is high.
// The count is held at zero while disabled, so the first tick after enabling
// arrives exactly HALF_PERIOD cycles later.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   en   - run the timer
//   tick - one-cycle pulse at the end of each half-period
module spi_clk_div #(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// spi_master: single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// A transfer starts when ready_send is high in IDLE; data_in is captured then
// and ignored afterwards. miso is sampled on every sclk rising edge and mosi
// changes on every sclk falling edge. After 8 sclk periods the received byte
// is loaded into data_out and ss drops.
// Optional feature: define SPI_DONE_EN to add the 'done' output, a one-cycle
// pulse coincident with the data_out update.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   miso       - serial data from slave
//   data_in    - byte to transmit
//   ready_send - level request to start a transfer
//   mosi       - serial data to slave
//   sclk       - serial clock, idles low
//   ss         - slave select, active-high
//   data_out   - last fully received byte
//   done       - (SPI_DONE_EN only) completion pulse
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miso,
  input  logic [SPI_WIDTH-1:0] data_in,
  input  logic                 ready_send,
  output logic                 mosi,
  output logic                 sclk,
  output logic                 ss,
  output logic [SPI_WIDTH-1:0] data_out
`ifdef SPI_DONE_EN
  ,
  output logic                 done
`endif
);

  localparam logic [3:0] LAST_BIT = 4'(SPI_WIDTH - 1);

  spi_state_t state_reg, state_next;

  // mosi itself carries the current bit, so the TX register only holds the
  // bits still to be sent.
  logic [SPI_WIDTH-2:0] tx_reg;
  logic [SPI_WIDTH-1:0] rx_reg;
  logic [3:0]           bit_cnt;
  logic                 tick;
  logic                 start, rise, fall, last_fall;

  spi_clk_div #(.HALF_PERIOD(HALF_PERIOD)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_reg != IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    last_fall  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ready_send) begin
          start      = 1'b1;
          state_next = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          rise       = 1'b1;
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          fall       = 1'b1;
          last_fall  = (bit_cnt == LAST_BIT);
          state_next = last_fall ? IDLE : LOW;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg   <= '0;
      rx_reg   <= '0;
      bit_cnt  <= '0;
      mosi     <= 1'b0;
      sclk     <= 1'b0;
      ss       <= 1'b0;
      data_out <= '0;
    end else begin
      if (start) begin
        tx_reg  <= data_in[SPI_WIDTH-2:0];
        mosi    <= data_in[SPI_WIDTH-1];
        ss      <= 1'b1;
        sclk    <= 1'b0;
        bit_cnt <= '0;
      end
      if (rise) begin
        sclk   <= 1'b1;
        rx_reg <= {rx_reg[SPI_WIDTH-2:0], miso};
      end
      if (fall) begin
        sclk    <= 1'b0;
        bit_cnt <= bit_cnt + 4'd1;
        if (last_fall) begin
          data_out <= rx_reg;
          ss       <= 1'b0;
          mosi     <= 1'b0;
        end else begin
          mosi   <= tx_reg[SPI_WIDTH-2];
          tx_reg <= {tx_reg[SPI_WIDTH-3:0], 1'b0};
        end
      end
    end
  end

`ifdef SPI_DONE_EN
  logic done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_reg <= 1'b0;
    else     done_reg <= last_fall;
  end

  assign done = done_reg;
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master.
// dut  runs at HALF_PERIOD=1 against a mode-0 slave model,
// dut3 runs at HALF_PERIOD=3 with miso tied high.
// With SPI_DONE_EN defined the done pulse is checked as well.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       ready_send = 1'b0;
  logic       ready_send3 = 1'b0;
  logic       miso;
  logic       mosi, sclk, ss;
  logic [7:0] data_out;
  logic       mosi3, sclk3, ss3;
  logic [7:0] data_out3;
  logic       obs_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef SPI_DONE_EN
  logic done, done3;
`endif

  spi_master #(.HALF_PERIOD(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .miso       (miso),
    .data_in    (data_in),
    .ready_send (ready_send),
    .mosi       (mosi),
    .sclk       (sclk),
    .ss         (ss),
    .data_out   (data_out)
`ifdef SPI_DONE_EN
    ,
    .done       (done)
`endif
  );

  spi_master #(.HALF_PERIOD(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .miso       (1'b1),
    .data_in    (data_in),
    .ready_send (ready_send3),
    .mosi       (mosi3),
    .sclk       (sclk3),
    .ss         (ss3),
    .data_out   (data_out3)
`ifdef SPI_DONE_EN
    ,
    .done       (done3)
`endif
  );

  // Slave model: loads its byte when ss rises, shifts on sclk falling edges.
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] sreg = 8'h00;
  logic       ss_d = 1'b0;
  logic       sclk_d = 1'b0;

  always @(posedge clk) begin
    #2;
    if (ss && !ss_d)
      sreg = slave_byte;
    else if (ss && sclk_d && !sclk)
      sreg = {sreg[6:0], 1'b0};
    ss_d = ss;
    sclk_d = sclk;
  end

  assign miso = sreg[7];

  // Observation mux: sel=0 watches dut, sel=1 watches dut3.
  bit   sel = 1'b0;
  logic obs_ss, obs_sclk, obs_mosi;
  assign obs_ss   = sel ? ss3   : ss;
  assign obs_sclk = sel ? sclk3 : sclk;
  assign obs_mosi = sel ? mosi3 : mosi;
`ifdef SPI_DONE_EN
  assign obs_done = sel ? done3 : done;
`else
  assign obs_done = 1'b0;
`endif

  int         o_rises, o_ss, o_done_cnt;
  logic [7:0] o_bits;
  bit         o_phase_bad, o_done_end;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watches one transfer from the current negedge until ss falls: counts
  // sclk rises, ss-high cycles, collects mosi at each rise and checks that
  // every sclk phase inside ss lasts hp cycles.
  task automatic observe(input int hp);
    logic prev;
    bit   seen;
    int   run;
    o_rises = 0; o_ss = 0; o_bits = 8'h00; o_phase_bad = 1'b0;
    o_done_cnt = 0; o_done_end = 1'b0;
    prev = obs_sclk; seen = 1'b0; run = 0;
    for (int i = 0; i < 400; i++) begin
      if (obs_done) o_done_cnt++;
      if (obs_ss) begin
        seen = 1'b1;
        o_ss++;
        if (run > 0 && obs_sclk != prev) begin
          if (run != hp) o_phase_bad = 1'b1;
          run = 0;
        end
        run++;
      end
      if (obs_sclk && !prev) begin
        o_rises++;
        o_bits = {o_bits[6:0], obs_mosi};
      end
      prev = obs_sclk;
      if (seen && !obs_ss) begin
        if (run != hp) o_phase_bad = 1'b1;
        o_done_end = obs_done;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rises, gap;
    logic prev;

    // Reset held for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", sclk, 1'b0);
    check("rst_ss", ss, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_data_out", data_out, 8'h00);
`ifdef SPI_DONE_EN
    check("rst_done", done, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Mid-transfer reset after the 4th sclk rising edge.
    data_in = 8'h13; slave_byte = 8'h37; ready_send = 1'b1;
    rises = 0; prev = sclk;
    for (int i = 0; i < 100 && rises < 4; i++) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    check("midrst_rises", rises, 4);
    check("midrst_pre_ss", ss, 1'b1);
    ready_send = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_ss", ss, 1'b0);
    check("midrst_mosi", mosi, 1'b0);
    check("midrst_data_out", data_out, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_after_ss", ss, 1'b0);
    check("midrst_after_data_out", data_out, 8'h00);

    // Basic loopback; data_in and ready_send change after the start is taken.
    data_in = 8'h13; slave_byte = 8'h37; ready_send = 1'b1;
    @(negedge clk);
    check("loop_start_ss", ss, 1'b1);
    data_in = 8'hFF; ready_send = 1'b0;
    observe(1);
    check("loop_rises", o_rises, 8);
    check("loop_mosi_bits", o_bits, 8'h13);
    check("loop_ss_cycles", o_ss, 16);
    check("loop_phase_bad", o_phase_bad, 1'b0);
    check("loop_end_mosi", mosi, 1'b0);
    check("loop_data_out", data_out, 8'h37);
`ifdef SPI_DONE_EN
    check("loop_done_count", o_done_cnt, 1);
    check("loop_done_with_data", o_done_end, 1'b1);
`endif
    repeat (3) @(negedge clk);
    check("loop_hold_data_out", data_out, 8'h37);
    check("loop_idle_ss", ss, 1'b0);

    // Held ready_send: two back-to-back transfers.
    data_in = 8'hA5; slave_byte = 8'hC3; ready_send = 1'b1;
    observe(1);
    check("b2b1_mosi_bits", o_bits, 8'hA5);
    check("b2b1_ss_cycles", o_ss, 16);
    check("b2b1_data_out", data_out, 8'hC3);
    data_in = 8'h5A; slave_byte = 8'h3C;
    gap = 0;
    for (int i = 0; i < 20 && !ss; i++) begin
      gap++;
      @(negedge clk);
    end
    check("b2b_gap", gap, 1);
    ready_send = 1'b0;
    observe(1);
    check("b2b2_mosi_bits", o_bits, 8'h5A);
    check("b2b2_ss_cycles", o_ss, 16);
    check("b2b2_data_out", data_out, 8'h3C);
    repeat (3) @(negedge clk);
    check("b2b_no_third", ss, 1'b0);

    // HALF_PERIOD=3 transfer on dut3 (miso tied high).
    sel = 1'b1;
    data_in = 8'h96; ready_send3 = 1'b1;
    observe(3);
    ready_send3 = 1'b0;
    check("hp3_rises", o_rises, 8);
    check("hp3_mosi_bits", o_bits, 8'h96);
    check("hp3_ss_cycles", o_ss, 48);
    check("hp3_phase_bad", o_phase_bad, 1'b0);
    check("hp3_data_out", data_out3, 8'hFF);
`ifdef SPI_DONE_EN
    check("hp3_done_count", o_done_cnt, 1);
    check("hp3_done_with_data", o_done_end, 1'b1);
`endif
    repeat (8) @(negedge clk);
    check("hp3_idle_ss", ss3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi

Interface
REQ-001 Parameter: HALF_PERIOD, default 1, number of clk cycles per sclk half-period (legal range 1..255).
REQ-002 Port: clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: miso  input  1  serial data from slave.
REQ-005 Port: data_in  input  8  byte to transmit; sampled at transfer start.
REQ-006 Port: ready_send  input  1  level request to start a transfer.
REQ-007 Port: mosi  output  1  serial data to slave, MSB first.
REQ-008 Port: sclk  output  1  serial clock; idles low (CPOL=0, CPHA=0).
REQ-009 Port: ss  output  1  slave select, active-high; high for the whole transfer.
REQ-010 Port: data_out  output  8  last fully received byte.

Function
REQ-011 The FSM SHALL have states IDLE, LOW (sclk low phase) and HIGH (sclk high phase).
REQ-012 In IDLE with ready_send=1, on the next clk edge the block SHALL latch data_in into the TX shift register, set ss=1, drive mosi=data_in[7], keep sclk=0, clear the bit counter and enter LOW.
REQ-013 LOW SHALL last HALF_PERIOD clk cycles, then sclk rises, miso is shifted into RX LSB, and the FSM enters HIGH.
REQ-014 HIGH SHALL last HALF_PERIOD clk cycles, then sclk falls and the bit counter increments.
REQ-015 On a falling edge with count<8, the TX register SHALL shift left and mosi SHALL present the next bit; the FSM returns to LOW.
REQ-016 On the 8th falling edge, in the same clk cycle, data_out SHALL load the RX register, ss SHALL drop to 0, mosi SHALL go to 0 and the FSM SHALL enter IDLE.
REQ-017 Each transfer SHALL be exactly 8 sclk periods; the first bit received lands in data_out[7].
REQ-018 Changes on data_in or ready_send during a transfer SHALL be ignored.
REQ-019 If ready_send is still 1 when the FSM returns to IDLE, a new transfer SHALL start after exactly one IDLE cycle with ss=0.
REQ-020 data_out SHALL hold its value between transfers and SHALL change only at REQ-016.
REQ-021 At HALF_PERIOD=1, ss SHALL be high for exactly 16 clk cycles per transfer.

Reset
REQ-022 While rst=1: state=IDLE, sclk=0, ss=0, mosi=0, data_out=8'h00, and the shift registers and counters are cleared.
REQ-023 Assertion of rst mid-transfer SHALL abort the transfer immediately, with no data_out update; after release the block waits for ready_send.

Configuration
REQ-024 With macro SPI_DONE_EN defined, an extra output done (1 bit) SHALL pulse high for one clk cycle, coincident with the data_out update; without the macro the port and its logic SHALL be absent.

Structure
REQ-025 Shared package spi_pkg SHALL hold the FSM state enum (IDLE, LOW, HIGH) and the constant SPI_WIDTH=8.
REQ-026 The sclk half-period counter SHALL be one sub-module, spi_clk_div, which emits a one-cycle tick every HALF_PERIOD cycles while enabled.

Verification
REQ-027 Reset: hold rst=1 for 2 cycles -> sclk=0, ss=0, mosi=0, data_out=8'h00.
REQ-028 Basic loopback: data_in=8'h13, ready_send=1, slave model drives 8'h37 MSB first on falling edges -> mosi bit sequence is 0,0,0,1,0,0,1,1, with 8 sclk rising edges; then ss=0 and data_out=8'h37.
REQ-029 Held ready_send: two back-to-back transfers (8'hA5, then 8'h5A) -> exactly one ss=0 cycle between them, and each data_out matches the slave byte.
REQ-030 Mid-transfer reset: assert rst after the 4th rising edge -> outputs return to reset values immediately, and data_out stays 8'h00.
REQ-031 HALF_PERIOD=3: one transfer -> sclk high and low phases are 3 clk cycles each, and ss is high for 48 cycles.
REQ-032 With SPI_DONE_EN defined: one transfer -> done is high for exactly one cycle, in the same cycle data_out updates.
